// File: rtl/bus_terminate_pkg.sv
// bus_terminate_pkg: decode encodings, termination codes and FSM states shared by bus_terminate
package bus_terminate_pkg;
  localparam int FUNCTION_SELECTED_MAXPOS = 3;
  localparam int FUNCTION_NORMAL  = 0;
  localparam int FUNCTION_INT_ACK = 1;
  localparam int FUNCTION_FPU     = 2;
  localparam int DEVICE_SELECTED_MAXPOS = 12;
  localparam int DEVICE_NULL       = 0;
  localparam int DEVICE_ROM        = 1;
  localparam int DEVICE_SLOT0      = 2;
  localparam int DEVICE_SLOT1      = 3;
  localparam int DEVICE_SLOT2      = 4;
  localparam int DEVICE_SLOT3      = 5;
  localparam int DEVICE_IDE1       = 6;
  localparam int DEVICE_IDE3       = 7;
  localparam int DEVICE_ETH        = 8;
  localparam int DEVICE_QUART      = 9;
  localparam int DEVICE_REGISTER8  = 10;
  localparam int DEVICE_REGISTER32 = 11;
  localparam int PORT_WIDTH_WIDTH = 2;
  localparam logic [1:0] PORT_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] PORT_WIDTH_WORD = 2'd1;
  localparam logic [1:0] PORT_WIDTH_LONG = 2'd2;
  localparam logic [1:0] PORT_WIDTH_NULL = 2'd3;
  localparam logic [1:0] DSACK_NONE = 2'b00;
  localparam logic [1:0] DSACK_BYTE = 2'b01;
  localparam logic [1:0] DSACK_WORD = 2'b10;
  localparam logic [1:0] DSACK_LONG = 2'b11;
  typedef enum logic [2:0] {
    TERM_STATE_IDLE,
    TERM_STATE_WAIT,
    TERM_STATE_TERM,
    TERM_STATE_ERROR,
    TERM_STATE_FPU_PASS
  } term_state_e;
  function automatic logic [1:0] width_dsack(input logic [PORT_WIDTH_WIDTH-1:0] w);
    return w == PORT_WIDTH_BYTE ? DSACK_BYTE :
           w == PORT_WIDTH_WORD ? DSACK_WORD :
           w == PORT_WIDTH_LONG ? DSACK_LONG : DSACK_NONE;
  endfunction
endpackage

// File: rtl/bus_terminate_bus_timeout.sv
// bus_timeout: 8-bit saturating cycle counter flagging an unanswered bus cycle
module bus_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [7:0] count;
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable && count != 8'hff) count <= count + 8'd1;
  // count lags the edge being evaluated by one, so the TIMEOUT_CYCLES-th edge sees TIMEOUT_CYCLES-1
  assign expired = count >= 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/bus_terminate.sv
// bus_terminate: 68030 cycle termination (dsack/avec/berr) with per-device wait states and bus watchdog
module bus_terminate
  import bus_terminate_pkg::*;
#(
  parameter int ROM_WAITS      = 2,
  parameter int SLOT_WAITS     = 1,
  parameter int QUART_WAITS    = 4,
  parameter int REGISTER_WAITS = 0,
  parameter int AVEC_WAITS     = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              as,
  input  logic [FUNCTION_SELECTED_MAXPOS-1:0] function_selected,
  input  logic [DEVICE_SELECTED_MAXPOS-1:0]   device_selected,
  input  logic [PORT_WIDTH_WIDTH-1:0]         port_width,
  input  logic                              ext_ready,
  output logic [1:0]                        dsack,
  output logic                              avec,
  output logic                              berr
);
  // {ready_required, wait_states}
  function automatic logic [8:0] device_timing(input logic [DEVICE_SELECTED_MAXPOS-1:0] dev);
    logic slot;
    slot = |{dev[DEVICE_SLOT0], dev[DEVICE_SLOT1], dev[DEVICE_SLOT2], dev[DEVICE_SLOT3],
             dev[DEVICE_IDE1], dev[DEVICE_IDE3], dev[DEVICE_ETH]};
    return slot ? {1'b1, 8'(SLOT_WAITS)} :
           dev[DEVICE_ROM] ? {1'b0, 8'(ROM_WAITS)} :
           dev[DEVICE_QUART] ? {1'b0, 8'(QUART_WAITS)} :
           (dev[DEVICE_REGISTER8] || dev[DEVICE_REGISTER32]) ? {1'b0, 8'(REGISTER_WAITS)} : 9'd0;
  endfunction
  term_state_e state;
  logic [7:0] wait_count;
  logic [1:0] term_dsack;
  logic       need_ready, is_iack, expired;
  logic [8:0] timing;
  logic       iack, fpu, bad;
  assign timing = device_timing(device_selected);
  assign iack = function_selected[FUNCTION_INT_ACK];
  assign fpu = function_selected[FUNCTION_FPU];
  assign bad = !function_selected[FUNCTION_NORMAL] || device_selected[DEVICE_NULL] ||
               device_selected == '0 || port_width == PORT_WIDTH_NULL;
  bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == TERM_STATE_IDLE),
    .enable  (state == TERM_STATE_WAIT || state == TERM_STATE_FPU_PASS),
    .expired (expired)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= TERM_STATE_IDLE;
      wait_count <= '0;
      term_dsack <= DSACK_NONE;
      need_ready <= 1'b0;
      is_iack <= 1'b0;
      dsack <= DSACK_NONE;
      avec <= 1'b0;
      berr <= 1'b0;
    end else if (state != TERM_STATE_IDLE && !as) begin
      state <= TERM_STATE_IDLE;
      dsack <= DSACK_NONE;
      avec <= 1'b0;
      berr <= 1'b0;
    end else begin
      case (state)
        TERM_STATE_IDLE: if (as) begin
          is_iack <= iack;
          need_ready <= !iack && timing[8];
          term_dsack <= width_dsack(port_width);
          wait_count <= iack ? 8'(AVEC_WAITS) : timing[7:0];
          state <= iack ? TERM_STATE_WAIT : fpu ? TERM_STATE_FPU_PASS :
                   bad ? TERM_STATE_ERROR : TERM_STATE_WAIT;
        end
        // ready qualification is checked before expiry so termination wins a tie
        TERM_STATE_WAIT:
          if (wait_count == 8'd0 && (ext_ready || !need_ready)) begin
            state <= TERM_STATE_TERM;
            dsack <= is_iack ? DSACK_NONE : term_dsack;
            avec <= is_iack;
          end else if (expired) begin
            state <= TERM_STATE_ERROR;
            berr <= 1'b1;
          end else if (wait_count != 8'd0) wait_count <= wait_count - 8'd1;
        TERM_STATE_FPU_PASS: if (expired) begin
          state <= TERM_STATE_ERROR;
          berr <= 1'b1;
        end
        TERM_STATE_ERROR: berr <= 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_bus_terminate.sv
// tb_bus_terminate: directed scenario checks of bus_terminate timing with default parameters
module tb_bus_terminate;
  import bus_terminate_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic as = 1'b0;
  logic [FUNCTION_SELECTED_MAXPOS-1:0] function_selected = '0;
  logic [DEVICE_SELECTED_MAXPOS-1:0] device_selected = '0;
  logic [PORT_WIDTH_WIDTH-1:0] port_width = '0;
  logic ext_ready = 1'b0;
  logic [1:0] dsack;
  logic avec, berr;
  logic [3:0] obs;
  int checks = 0;
  int errors = 0;
  bus_terminate dut (
    .clock             (clock),
    .reset             (reset),
    .as                (as),
    .function_selected (function_selected),
    .device_selected   (device_selected),
    .port_width        (port_width),
    .ext_ready         (ext_ready),
    .dsack             (dsack),
    .avec              (avec),
    .berr              (berr)
  );
  always #5 clock = ~clock;
  assign obs = {dsack, avec, berr};
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic start(input int f, input int d, input logic [1:0] w);
    function_selected = FUNCTION_SELECTED_MAXPOS'(1 << f);
    device_selected = DEVICE_SELECTED_MAXPOS'(1 << d);
    port_width = w;
    as = 1'b1;
    tick(1);
  endtask
  task automatic stop_cycle;
    as = 1'b0;
    ext_ready = 1'b0;
    tick(1);
  endtask
  task automatic test_reset;
    tick(2);
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_hold got=%b exp=%b", obs, 4'b0000); end
    checks++;
    reset = 1'b0;
    tick(1);
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_release got=%b exp=%b", obs, 4'b0000); end
    checks++;
  endtask
  task automatic test_rom_word;
    start(FUNCTION_NORMAL, DEVICE_ROM, PORT_WIDTH_WORD);
    if (obs !== 4'b0000) begin errors++; $display("FAIL rom_e0 got=%b exp=%b", obs, 4'b0000); end
    checks++;
    device_selected = DEVICE_SELECTED_MAXPOS'(1 << DEVICE_REGISTER32);
    port_width = PORT_WIDTH_LONG;
    tick(2);
    if (obs !== 4'b0000) begin errors++; $display("FAIL rom_e2 got=%b exp=%b", obs, 4'b0000); end
    checks++;
    tick(1);
    if (obs !== 4'b1000) begin errors++; $display("FAIL rom_e3 got=%b exp=%b", obs, 4'b1000); end
    checks++;
    tick(1);
    if (obs !== 4'b1000) begin errors++; $display("FAIL rom_hold got=%b exp=%b", obs, 4'b1000); end
    checks++;
    stop_cycle();
    if (obs !== 4'b0000) begin errors++; $display("FAIL rom_negate got=%b exp=%b", obs, 4'b0000); end
    checks++;
  endtask
  task automatic test_register_quart;
    start(FUNCTION_NORMAL, DEVICE_REGISTER32, PORT_WIDTH_LONG);
    tick(1);
    if (obs !== 4'b1100) begin errors++; $display("FAIL reg32_e1 got=%b exp=%b", obs, 4'b1100); end
    checks++;
    stop_cycle();
    start(FUNCTION_NORMAL, DEVICE_QUART, PORT_WIDTH_BYTE);
    tick(4);
    if (obs !== 4'b0000) begin errors++; $display("FAIL quart_e4 got=%b exp=%b", obs, 4'b0000); end
    checks++;
    tick(1);
    if (obs !== 4'b0100) begin errors++; $display("FAIL quart_e5 got=%b exp=%b", obs, 4'b0100); end
    checks++;
    stop_cycle();
  endtask
  task automatic test_slot_ready;
    logic seen;
    start(FUNCTION_NORMAL, DEVICE_SLOT1, PORT_WIDTH_WORD);
    tick(10);
    if (obs !== 4'b0000) begin errors++; $display("FAIL slot_e10 got=%b exp=%b", obs, 4'b0000); end
    checks++;
    ext_ready = 1'b1;
    tick(1);
    if (obs !== 4'b1000) begin errors++; $display("FAIL slot_e11 got=%b exp=%b", obs, 4'b1000); end
    checks++;
    stop_cycle();
    seen = 1'b0;
    start(FUNCTION_NORMAL, DEVICE_SLOT1, PORT_WIDTH_WORD);
    for (int i = 1; i < 64; i++) begin
      tick(1);
      if (obs !== 4'b0000) seen = 1'b1;
    end
    if (seen !== 1'b0) begin errors++; $display("FAIL slot_stuck_early got=%b exp=%b", seen, 1'b0); end
    checks++;
    tick(1);
    if (obs !== 4'b0001) begin errors++; $display("FAIL slot_stuck_e64 got=%b exp=%b", obs, 4'b0001); end
    checks++;
    stop_cycle();
  endtask
  task automatic test_null_fpu;
    logic seen;
    start(FUNCTION_NORMAL, DEVICE_NULL, PORT_WIDTH_WORD);
    if (obs !== 4'b0000) begin errors++; $display("FAIL null_e0 got=%b exp=%b", obs, 4'b0000); end
    checks++;
    tick(1);
    if (obs !== 4'b0001) begin errors++; $display("FAIL null_e1 got=%b exp=%b", obs, 4'b0001); end
    checks++;
    tick(1);
    if (obs !== 4'b0001) begin errors++; $display("FAIL null_hold got=%b exp=%b", obs, 4'b0001); end
    checks++;
    stop_cycle();
    if (obs !== 4'b0000) begin errors++; $display("FAIL null_negate got=%b exp=%b", obs, 4'b0000); end
    checks++;
    start(FUNCTION_NORMAL, DEVICE_ROM, PORT_WIDTH_NULL);
    tick(1);
    if (obs !== 4'b0001) begin errors++; $display("FAIL pwnull_e1 got=%b exp=%b", obs, 4'b0001); end
    checks++;
    stop_cycle();
    seen = 1'b0;
    start(FUNCTION_FPU, DEVICE_ROM, PORT_WIDTH_LONG);
    for (int i = 1; i < 64; i++) begin
      tick(1);
      if (obs !== 4'b0000) seen = 1'b1;
    end
    if (seen !== 1'b0) begin errors++; $display("FAIL fpu_early got=%b exp=%b", seen, 1'b0); end
    checks++;
    tick(1);
    if (obs !== 4'b0001) begin errors++; $display("FAIL fpu_e64 got=%b exp=%b", obs, 4'b0001); end
    checks++;
    stop_cycle();
  endtask
  task automatic test_int_ack;
    start(FUNCTION_INT_ACK, DEVICE_ROM, PORT_WIDTH_LONG);
    tick(1);
    if (obs !== 4'b0000) begin errors++; $display("FAIL iack_e1 got=%b exp=%b", obs, 4'b0000); end
    checks++;
    tick(1);
    if (obs !== 4'b0010) begin errors++; $display("FAIL iack_e2 got=%b exp=%b", obs, 4'b0010); end
    checks++;
    stop_cycle();
  endtask
  task automatic test_abort_reset;
    start(FUNCTION_NORMAL, DEVICE_ROM, PORT_WIDTH_WORD);
    as = 1'b0;
    tick(1);
    if (obs !== 4'b0000) begin errors++; $display("FAIL abort_e1 got=%b exp=%b", obs, 4'b0000); end
    checks++;
    start(FUNCTION_NORMAL, DEVICE_ROM, PORT_WIDTH_WORD);
    tick(2);
    if (obs !== 4'b0000) begin errors++; $display("FAIL b2b_e2 got=%b exp=%b", obs, 4'b0000); end
    checks++;
    tick(1);
    if (obs !== 4'b1000) begin errors++; $display("FAIL b2b_e3 got=%b exp=%b", obs, 4'b1000); end
    checks++;
    reset = 1'b1;
    #1;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_in_term got=%b exp=%b", obs, 4'b0000); end
    checks++;
    as = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_after got=%b exp=%b", obs, 4'b0000); end
    checks++;
  endtask
  task automatic test_race;
    start(FUNCTION_NORMAL, DEVICE_SLOT1, PORT_WIDTH_WORD);
    tick(63);
    if (obs !== 4'b0000) begin errors++; $display("FAIL race_e63 got=%b exp=%b", obs, 4'b0000); end
    checks++;
    ext_ready = 1'b1;
    tick(1);
    if (obs !== 4'b1000) begin errors++; $display("FAIL race_e64 got=%b exp=%b", obs, 4'b1000); end
    checks++;
    tick(1);
    if (obs !== 4'b1000) begin errors++; $display("FAIL race_hold got=%b exp=%b", obs, 4'b1000); end
    checks++;
    stop_cycle();
  endtask
  initial begin
    test_reset();
    test_rom_word();
    test_register_quart();
    test_slot_ready();
    test_null_fpu();
    test_int_ack();
    test_abort_reset();
    test_race();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
